// File: rtl/apb_mig_bridge.sv
// apb_mig_bridge: APB slave to MIG UI bridge, one line transaction per APB access; define APB_MIG_READ_CACHE_EN for a one-line read cache
module apb_mig_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int MIG_ADDR_WIDTH = 27,
  parameter int MIG_DATA_WIDTH = 128,
  parameter int ADDR_SHIFT     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]   pwdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] pstrb_i,
  output logic                        pready_o,
  output logic [APB_DATA_WIDTH-1:0]   prdata_o,
  output logic                        pslverr_o,
  output logic [MIG_ADDR_WIDTH-1:0]   app_addr_o,
  output logic [2:0]                  app_cmd_o,
  output logic                        app_en_o,
  input  logic                        app_rdy_i,
  output logic [MIG_DATA_WIDTH-1:0]   app_wdf_data_o,
  output logic [MIG_DATA_WIDTH/8-1:0] app_wdf_mask_o,
  output logic                        app_wdf_wren_o,
  output logic                        app_wdf_end_o,
  input  logic                        app_wdf_rdy_i,
  input  logic [MIG_DATA_WIDTH-1:0]   app_rd_data_i,
  input  logic                        app_rd_data_valid_i
);
  localparam int LINE_BYTES = MIG_DATA_WIDTH / 8;
  localparam int APB_BYTES  = APB_DATA_WIDTH / 8;
  localparam int LANES      = MIG_DATA_WIDTH / APB_DATA_WIDTH;
  localparam int LB         = $clog2(LINE_BYTES);
  localparam int AB         = $clog2(APB_BYTES);
  localparam int LW         = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RS         = MIG_ADDR_WIDTH + ADDR_SHIFT;

  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, RESP} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [LW-1:0]             lane;
  logic [LW-1:0]             lane_w;
  logic [MIG_ADDR_WIDTH-1:0] addr_w;
  logic                      err_w;
  logic                      hit;
  logic                      tmo;
  logic [APB_DATA_WIDTH-1:0] hit_data;

  assign lane_w        = LW'((paddr_i >> AB) & APB_ADDR_WIDTH'(LANES - 1));
  assign addr_w        = MIG_ADDR_WIDTH'((paddr_i >> LB) << (LB - ADDR_SHIFT));
  assign err_w         = ((paddr_i >> RS) != '0) || ((paddr_i & APB_ADDR_WIDTH'(APB_BYTES - 1)) != '0);
  assign tmo           = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign app_wdf_end_o = app_wdf_wren_o;

`ifdef APB_MIG_READ_CACHE_EN
  logic [MIG_DATA_WIDTH-1:0] cache_data;
  logic [MIG_ADDR_WIDTH-1:0] cache_addr;
  logic                      cache_vld;

  assign hit      = cache_vld && !pwrite_i && !err_w && cache_addr == addr_w;
  assign hit_data = cache_data[lane_w * APB_DATA_WIDTH +: APB_DATA_WIDTH];

  // Cache fills on read return, drops on a failed fill, and merges accepted write bytes for the held line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cache_vld  <= 1'b0;
      cache_data <= '0;
      cache_addr <= '0;
    end else if (state == RD_WAIT && app_rd_data_valid_i) begin
      cache_data <= app_rd_data_i;
      cache_addr <= app_addr_o;
      cache_vld  <= 1'b1;
    end else if (tmo && ((state == RD_CMD && !app_rdy_i) || state == RD_WAIT)) begin
      cache_vld <= 1'b0;
    end else if (app_wdf_wren_o && app_wdf_rdy_i && cache_vld && cache_addr == app_addr_o) begin
      for (int b = 0; b < LINE_BYTES; b++)
        if (!app_wdf_mask_o[b]) cache_data[b*8 +: 8] <= app_wdf_data_o[b*8 +: 8];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Transfer FSM; all APB and MIG outputs are registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      lane           <= '0;
      pready_o       <= 1'b0;
      prdata_o       <= '0;
      pslverr_o      <= 1'b0;
      app_addr_o     <= '0;
      app_cmd_o      <= 3'b000;
      app_en_o       <= 1'b0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '1;
      app_wdf_wren_o <= 1'b0;
    end else begin
      pready_o <= 1'b0;
      cnt      <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (psel_i && penable_i) begin
            app_addr_o <= addr_w;
            lane       <= lane_w;
            if (err_w || hit) begin
              state     <= RESP;
              pready_o  <= 1'b1;
              pslverr_o <= err_w;
              prdata_o  <= err_w ? '0 : hit_data;
            end else if (pwrite_i) begin
              state          <= WR;
              app_en_o       <= 1'b1;
              app_cmd_o      <= 3'b000;
              app_wdf_wren_o <= 1'b1;
              app_wdf_data_o <= {LANES{pwdata_i}};
              app_wdf_mask_o <= ~(LINE_BYTES'(pstrb_i) << (lane_w * APB_BYTES));
            end else begin
              state     <= RD_CMD;
              app_en_o  <= 1'b1;
              app_cmd_o <= 3'b001;
            end
          end
        end
        WR: begin
          if (app_rdy_i) app_en_o <= 1'b0;
          if (app_wdf_rdy_i) app_wdf_wren_o <= 1'b0;
          if ((!app_en_o || app_rdy_i) && (!app_wdf_wren_o || app_wdf_rdy_i)) begin
            state     <= RESP;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b0;
          end else if (tmo) begin
            state          <= RESP;
            pready_o       <= 1'b1;
            pslverr_o      <= 1'b1;
            prdata_o       <= '0;
            app_en_o       <= 1'b0;
            app_wdf_wren_o <= 1'b0;
          end
        end
        RD_CMD: begin
          if (app_rdy_i) begin
            state    <= RD_WAIT;
            app_en_o <= 1'b0;
            cnt      <= '0;
          end else if (tmo) begin
            state     <= RESP;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b1;
            prdata_o  <= '0;
            app_en_o  <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (app_rd_data_valid_i) begin
            state     <= RESP;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b0;
            prdata_o  <= app_rd_data_i[lane * APB_DATA_WIDTH +: APB_DATA_WIDTH];
          end else if (tmo) begin
            state     <= RESP;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b1;
            prdata_o  <= '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_mig_bridge.sv
// tb_apb_mig_bridge: directed APB transfers against a small MIG responder, scoreboard-checked responses
module tb_apb_mig_bridge;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic         pready_o, pslverr_o;
  logic [31:0]  prdata_o;
  logic [26:0]  app_addr_o;
  logic [2:0]   app_cmd_o;
  logic         app_en_o, app_rdy_i;
  logic [127:0] app_wdf_data_o;
  logic [15:0]  app_wdf_mask_o;
  logic         app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic [127:0] app_rd_data_i;
  logic         app_rd_data_valid_i;

  int           rdy_dly = 0, wdf_dly = 0, rd_lat = 5;
  logic         rdy_block = 1'b0, stray = 1'b0;
  logic [127:0] rd_line = 128'h33333333_CAFEF00D_22222222_11111111;

  int           cyc = 0, en_age = 0, wdf_age = 0, rd_cd = 0, en_cnt = 0, wren_cnt = 0;
  logic [26:0]  cap_addr = '0;
  logic [2:0]   cap_cmd = '0;
  logic [127:0] cap_data = '0;
  logic [15:0]  cap_mask = '0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
    logic        chk_d;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_fail = 0;

  apb_mig_bridge dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready_o),
    .prdata_o(prdata_o), .pslverr_o(pslverr_o), .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o),
    .app_en_o(app_en_o), .app_rdy_i(app_rdy_i), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_rdy_i(app_wdf_rdy_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_valid_i(app_rd_data_valid_i)
  );

  always #5 clk = ~clk;

  assign app_rdy_i           = !rdy_block && en_age >= rdy_dly;
  assign app_wdf_rdy_i       = wdf_age >= wdf_dly;
  assign app_rd_data_i       = rd_line;
  assign app_rd_data_valid_i = rd_cd == 1 || stray;

  // MIG responder: handshake ages, activity counters, captured command/data, delayed read return
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    en_age   <= app_en_o ? en_age + 1 : 0;
    wdf_age  <= app_wdf_wren_o ? wdf_age + 1 : 0;
    en_cnt   <= en_cnt + int'(app_en_o);
    wren_cnt <= wren_cnt + int'(app_wdf_wren_o);
    if (app_en_o && app_rdy_i) begin
      cap_addr <= app_addr_o;
      cap_cmd  <= app_cmd_o;
      rd_cd    <= app_cmd_o == 3'b001 ? rd_lat : 0;
    end else if (rd_cd != 0) rd_cd <= rd_cd - 1;
    if (app_wdf_wren_o && app_wdf_rdy_i) begin
      cap_data <= app_wdf_data_o;
      cap_mask <= app_wdf_mask_o;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every pready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (pready_o) begin
      if (sb.size() == 0) chk("pready_without_request", pready_o, 1'b0);
      else begin
        e = sb.pop_front();
        chk("pslverr", pslverr_o, e.e);
        if (e.chk_d) chk("prdata", prdata_o, e.d);
        if (e.lat >= 0) chk("latency", 128'(cyc - e.t), 128'(e.lat));
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input logic chk_d,
                      input int exp_en, input int exp_wren);
    int e0, w0, n;
    e0 = en_cnt;
    w0 = wren_cnt;
    n  = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    sb.push_back('{d: exp_d, e: exp_e, lat: exp_lat, chk_d: chk_d, t: cyc});
    do begin
      @(negedge clk);
      n++;
    end while (!pready_o && n < 3000);
    if (!pready_o) chk("pready_wait", pready_o, 1'b1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("app_en_cycles", 128'(en_cnt - e0), 128'(exp_en));
    chk("wren_cycles", 128'(wren_cnt - w0), 128'(exp_wren));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pready", pready_o, 1'b0);
    chk("rst_pslverr", pslverr_o, 1'b0);
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_app_en", app_en_o, 1'b0);
    chk("rst_wren", app_wdf_wren_o, 1'b0);
    chk("rst_wdf_end", app_wdf_end_o, 1'b0);
    chk("rst_mask", app_wdf_mask_o, 16'hFFFF);
    chk("rst_app_addr", app_addr_o, 27'h0);

    // full-word write, both ready lines high
    xfer(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1'b0, 1, 1);
    chk("wr_addr", cap_addr, 27'h8);
    chk("wr_cmd", cap_cmd, 3'b000);
    chk("wr_mask", cap_mask, 16'hFF0F);
    chk("wr_data", cap_data, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);

    // read with 5-cycle return latency
    xfer(1'b0, 32'h18, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 7, 1'b1, 1, 0);
    chk("rd_addr", cap_addr, 27'h8);
    chk("rd_cmd", cap_cmd, 3'b001);

    // range and alignment errors, plus the highest legal word
    xfer(1'b1, 32'h1000_0000, 32'h5, 4'hF, 32'h0, 1'b1, 1, 1'b0, 0, 0);
    xfer(1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b0, 0, 0);
    xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 32'h33333333, 1'b0, 7, 1'b1, 1, 0);
    chk("top_addr", cap_addr, 27'h7FFFFF8);

    // command never accepted: timeout, then a normal read
    rdy_block = 1'b1;
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1025, 1'b1, 1024, 0);
    rdy_block = 1'b0;
    xfer(1'b0, 32'h24, 32'h0, 4'h0, 32'h22222222, 1'b0, 7, 1'b1, 1, 0);
    chk("post_tmo_addr", cap_addr, 27'h10);

    // write data accepted 3 cycles after the command
    wdf_dly = 3;
    xfer(1'b1, 32'h30, 32'h12345678, 4'h3, 32'h0, 1'b0, 5, 1'b0, 1, 4);
    chk("dly_mask", cap_mask, 16'hFFFC);
    chk("dly_addr", cap_addr, 27'h18);
    wdf_dly = 0;

    // stray read-valid while idle must be ignored
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    xfer(1'b0, 32'h1C, 32'h0, 4'h0, 32'h33333333, 1'b0, 7, 1'b1, 1, 0);

    // read-cache sequence; without the cache every read goes to MIG
`ifdef APB_MIG_READ_CACHE_EN
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 32'h11111111, 1'b0, 7, 1'b1, 1, 0);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 32'h22222222, 1'b0, 1, 1'b1, 0, 0);
    xfer(1'b1, 32'h44, 32'h1, 4'hF, 32'h0, 1'b0, 2, 1'b0, 1, 1);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 32'h00000001, 1'b0, 1, 1'b1, 0, 0);
`else
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 32'h11111111, 1'b0, 7, 1'b1, 1, 0);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 32'h22222222, 1'b0, 7, 1'b1, 1, 0);
    xfer(1'b1, 32'h44, 32'h1, 4'hF, 32'h0, 1'b0, 2, 1'b0, 1, 1);
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 32'h22222222, 1'b0, 7, 1'b1, 1, 0);
`endif
    chk("cache_wr_mask", cap_mask, 16'hFF0F);

    repeat (4) @(posedge clk);
    #1 chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
